// File: rtl/prod_pkg.sv
// prod_pkg: shared types, constants and helpers for the FP32 product chain.
package prod_pkg;

  localparam int          FP32_W        = 32;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  // Sequencer states of the product chain.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    DONE,
    HOLD
  } prod_state_t;

  // Observation bundle: chain state plus the shared multiplier's state.
  typedef struct packed {
    prod_state_t state;
    logic [1:0]  mult_state;
  } prod_dbg_t;

  // True for +0 and -0 (sign ignored).
  function automatic logic fp32_is_zero(input logic [FP32_W-1:0] v);
    return (v[FP32_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/multiplier.sv
// multiplier: single FP32 multiply with STB/BUSY handshake on both sides.
// Round-to-nearest-even, gradual underflow, overflow to Inf, canonical qNaN.
module multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_STB,
  output logic        BUSY,
  output logic [31:0] output_z,
  output logic        output_STB,
  input  logic        output_module_BUSY,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {M_IDLE, M_CALC, M_OUT} mult_state_t;

  mult_state_t state;
  logic [31:0] a_q;
  logic [31:0] b_q;

  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]         ea_eff, eb_eff;
    logic [23:0]        sig_a, sig_b;
    logic [47:0]        p, pn;
    logic [71:0]        ext;
    logic [5:0]         lz;
    logic signed [11:0] e_n;
    logic [11:0]        sh;
    logic [30:0]        mag;
    logic               g, st;
    logic [31:0]        r;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    // Denormals use exponent 1 with no hidden bit.
    ea_eff = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb_eff = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    sig_a  = {(a[30:23] != 8'd0), a[22:0]};
    sig_b  = {(b[30:23] != 8'd0), b[22:0]};
    p      = 48'(sig_a) * 48'(sig_b);
    lz     = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (p[i]) lz = 6'(47 - i);
    end
    // Leading one moved to bit 47; exponent follows the shift.
    pn  = p << lz;
    e_n = signed'(12'(ea_eff) + 12'(eb_eff) - 12'd126 - 12'(lz));
    sh  = unsigned'(12'sd1 - e_n);
    ext = '0;
    mag = '0;
    g   = 1'b0;
    st  = 1'b0;
    r   = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      r = {s, 31'd0};
    end else if (e_n >= 12'sd255) begin
      r = {s, 8'hFF, 23'd0};
    end else if (e_n >= 12'sd1) begin
      mag = {e_n[7:0], pn[46:24]};
      g   = pn[23];
      st  = |pn[22:0];
      r   = {s, mag + 31'(g & (st | mag[0]))};
    end else if (sh >= 12'd25) begin
      // Below half of the smallest denormal: rounds to signed zero.
      r = {s, 31'd0};
    end else begin
      ext = {pn, 24'd0} >> sh;
      mag = {8'd0, ext[70:48]};
      g   = ext[47];
      st  = |ext[46:0];
      r   = {s, mag + 31'(g & (st | mag[0]))};
    end
    return r;
  endfunction

  // Accept one operand pair, compute for one cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= M_IDLE;
      BUSY       <= 1'b0;
      output_STB <= 1'b0;
      output_z   <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
    end else begin
      case (state)
        M_IDLE: begin
          if (input_STB && !BUSY) begin
            a_q   <= input_a;
            b_q   <= input_b;
            BUSY  <= 1'b1;
            state <= M_CALC;
          end
        end
        M_CALC: begin
          output_z   <= fp32_mul(a_q, b_q);
          output_STB <= 1'b1;
          state      <= M_OUT;
        end
        M_OUT: begin
          if (!output_module_BUSY) begin
            output_STB <= 1'b0;
            BUSY       <= 1'b0;
            state      <= M_IDLE;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: rtl/fp_product_chain.sv
// fp_product_chain: FP32 product ((op0*op1)*op2)*... of N_OPS operands,
// issued left to right through one shared multiplier.
// Optional build macro: PROD_ZERO_SKIP_EN (any zero operand short-circuits
// to a signed zero without starting the multiplier).
//
// Handshake (all STB/BUSY pairs here): a word moves on a clock edge where
// STB=1 and BUSY=0; the sender holds data and STB stable until that edge,
// and a receiver raising BUSY means no transfer happens that cycle.
module fp_product_chain
  import prod_pkg::*;
#(
  parameter int N_OPS = 4,
  parameter int CNT_W = $clog2(N_OPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FP32_W*N_OPS-1:0] input_ops,
  input  logic                    prod_input_STB,
  output logic                    prod_BUSY,
  output logic [FP32_W-1:0]       output_result,
  output logic                    prod_output_STB,
  input  logic                    output_module_BUSY,
  output prod_dbg_t               dbg
);

  if (N_OPS < 2 || N_OPS > 16) begin : g_bad_n_ops
    $error("fp_product_chain: N_OPS=%0d outside legal range 2..16", N_OPS);
  end

  prod_state_t       state;
  logic [FP32_W-1:0] ops_q [N_OPS];
  logic [FP32_W-1:0] acc;
  logic [CNT_W-1:0]  idx;
  logic              accept;

  logic              mult_input_STB;
  logic              mult_BUSY;
  logic [FP32_W-1:0] mult_result;
  logic              mult_output_STB;
  logic              mult_out_BUSY;
  logic [1:0]        mult_state;

  assign accept = prod_input_STB && !prod_BUSY;

`ifdef PROD_ZERO_SKIP_EN
  logic any_zero;
  logic sign_x;

  // Zero scan and sign parity over the incoming bundle.
  always_comb begin
    any_zero = 1'b0;
    sign_x   = 1'b0;
    for (int i = 0; i < N_OPS; i++) begin
      any_zero = any_zero | fp32_is_zero(input_ops[FP32_W*i +: FP32_W]);
      sign_x   = sign_x ^ input_ops[FP32_W*i + FP32_W - 1];
    end
  end
`endif

  // Capture the whole bundle on accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      for (int i = 0; i < N_OPS; i++) begin
        ops_q[i] <= input_ops[FP32_W*i +: FP32_W];
      end
    end
  end

  // Chain sequencer: issue acc*op[idx], fold the result back, present the total.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      prod_BUSY       <= 1'b0;
      prod_output_STB <= 1'b0;
      output_result   <= FP32_POS_ZERO;
      mult_input_STB  <= 1'b0;
      mult_out_BUSY   <= 1'b1;
      acc             <= FP32_POS_ZERO;
      idx             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx       <= CNT_W'(1);
            prod_BUSY <= 1'b1;
`ifdef PROD_ZERO_SKIP_EN
            if (any_zero) begin
              acc   <= {sign_x, {(FP32_W-1){1'b0}}};
              state <= DONE;
            end else begin
              acc            <= input_ops[FP32_W-1:0];
              mult_input_STB <= 1'b1;
              state          <= ISSUE;
            end
`else
            acc            <= input_ops[FP32_W-1:0];
            mult_input_STB <= 1'b1;
            state          <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          // Multiplier raising BUSY means it has taken this operand pair.
          if (mult_BUSY) begin
            mult_input_STB <= 1'b0;
            mult_out_BUSY  <= 1'b0;
            state          <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (mult_output_STB && !mult_out_BUSY) begin
            acc           <= mult_result;
            mult_out_BUSY <= 1'b1;
            if (idx == CNT_W'(N_OPS - 1)) begin
              state <= DONE;
            end else begin
              idx            <= idx + CNT_W'(1);
              mult_input_STB <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        DONE: begin
          output_result   <= acc;
          prod_output_STB <= 1'b1;
          state           <= HOLD;
        end
        HOLD: begin
          if (!output_module_BUSY) begin
            prod_output_STB <= 1'b0;
            prod_BUSY       <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  multiplier u_mult (
    .clk                (clk),
    .rst                (rst),
    .input_a            (acc),
    .input_b            (ops_q[idx]),
    .input_STB          (mult_input_STB),
    .BUSY               (mult_BUSY),
    .output_z           (mult_result),
    .output_STB         (mult_output_STB),
    .output_module_BUSY (mult_out_BUSY),
    .dbg_state          (mult_state)
  );

  assign dbg.state      = state;
  assign dbg.mult_state = mult_state;

endmodule

// File: tb/tb_fp_product_chain.sv
// tb_fp_product_chain: directed and randomized checks of fp_product_chain
// with N_OPS = 4, 2 and 16 instances; reference products come from real
// arithmetic on operands chosen so every product is exact in FP32.
module tb_fp_product_chain;
  import prod_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic [127:0] in4;
  logic         stb4, busy4, ostb4, obusy4;
  logic [31:0]  res4;
  prod_dbg_t    dbg4;

  logic [63:0]  in2;
  logic         stb2, busy2, ostb2, obusy2;
  logic [31:0]  res2;
  prod_dbg_t    dbg2;

  logic [511:0] in16;
  logic         stb16, busy16, ostb16, obusy16;
  logic [31:0]  res16;
  prod_dbg_t    dbg16;

  fp_product_chain #(.N_OPS(4)) u4 (
    .clk(clk), .rst(rst), .input_ops(in4), .prod_input_STB(stb4),
    .prod_BUSY(busy4), .output_result(res4), .prod_output_STB(ostb4),
    .output_module_BUSY(obusy4), .dbg(dbg4)
  );

  fp_product_chain #(.N_OPS(2)) u2 (
    .clk(clk), .rst(rst), .input_ops(in2), .prod_input_STB(stb2),
    .prod_BUSY(busy2), .output_result(res2), .prod_output_STB(ostb2),
    .output_module_BUSY(obusy2), .dbg(dbg2)
  );

  fp_product_chain #(.N_OPS(16)) u16 (
    .clk(clk), .rst(rst), .input_ops(in16), .prod_input_STB(stb16),
    .prod_BUSY(busy16), .output_result(res16), .prod_output_STB(ostb16),
    .output_module_BUSY(obusy16), .dbg(dbg16)
  );

  // Multiplier start counter for the N_OPS=4 instance.
  int unsigned starts4 = 0;
  always @(posedge clk) begin
    if (u4.mult_input_STB && !u4.mult_BUSY) starts4 <= starts4 + 1;
  end

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] ref_prod4(input logic [127:0] ops);
    real p;
    p = 1.0;
    for (int i = 0; i < 4; i++) p = p * to_real(ops[32*i +: 32]);
    return to_fp32(p);
  endfunction

  function automatic int exp_starts4(input logic [127:0] ops);
`ifdef PROD_ZERO_SKIP_EN
    for (int i = 0; i < 4; i++) begin
      if (ops[32*i +: 31] == 31'd0) return 0;
    end
`endif
    return 3;
  endfunction

  // Signed operand with a 4-bit significand and a small exponent, or a signed zero.
  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] e;
    logic [2:0] m;
    s = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) return {s, 31'd0};
    e = 8'(121 + $urandom_range(0, 12));
    m = 3'($urandom_range(0, 7));
    return {s, e, m, 20'd0};
  endfunction

  // ---------------- driver tasks (N_OPS=4) ----------------
  task automatic send4(input logic [127:0] ops);
    int n;
    n = 0;
    while (busy4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("send4_busy_timeout", 32'(busy4), 32'd0);
    stb4 = 1'b1;
    in4  = ops;
    @(posedge clk); #1;
    stb4 = 1'b0;
    in4  = ~ops;
  endtask

  // Returns the first presented result and the edges counted since accept.
  task automatic wait4(output logic [31:0] r, output int lat);
    lat = 0;
    while (!ostb4 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("wait4_stb", 32'(ostb4), 32'd1);
    r = res4;
  endtask

  task automatic release4(input string tag);
    @(posedge clk); #1;
    chk({tag, "_stb_drop"}, 32'(ostb4), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy4), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [127:0] ops;
    logic [127:0] t1;
    logic [31:0]  r;
    int           lat;
    int           n;
    int           hold;
    int unsigned  s0;

    rst = 1'b1;
    stb4 = 1'b0;  in4 = '0;  obusy4 = 1'b0;
    stb2 = 1'b0;  in2 = '0;  obusy2 = 1'b0;
    stb16 = 1'b0; in16 = '0; obusy16 = 1'b0;
    t1 = {32'h4080_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4000_0000};

    // Reset state
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_ostb", 32'(ostb4), 32'd0);
    chk("rst_result", res4, 32'd0);
    chk("rst_state", 32'(dbg4.state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: 2*3*0.5*4 = 12.0, three multiplier starts
    s0 = starts4;
    send4(t1);
    chk("t1_busy_after_accept", 32'(busy4), 32'd1);
    wait4(r, lat);
    chk("t1_result", r, 32'h4140_0000);
    chk("t1_mult_starts", starts4 - s0, 32'd3);
    release4("t1");

    // 2: 2*3*0.5*-2 = -6.0
    send4({32'hC000_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4000_0000});
    wait4(r, lat);
    chk("t2_result", r, 32'hC0C0_0000);
    release4("t2");

    // 3: a negative zero operand gives negative zero
    s0 = starts4;
    send4({32'h4080_0000, 32'h4040_0000, 32'h8000_0000, 32'h4000_0000});
    wait4(r, lat);
    chk("t3_result", r, 32'h8000_0000);
`ifdef PROD_ZERO_SKIP_EN
    // accept cycle, DONE cycle, then STB: one edge after the accept edge
    chk("t3_latency", 32'(lat), 32'd1);
    chk("t3_mult_starts", starts4 - s0, 32'd0);
`else
    chk("t3_mult_starts", starts4 - s0, 32'd3);
`endif
    release4("t3");

    // 4: backpressure holds result/STB/BUSY; new input ignored
    obusy4 = 1'b1;
    send4(t1);
    wait4(r, lat);
    chk("t4_result", r, 32'h4140_0000);
    for (int k = 0; k < 10; k++) begin
      stb4 = 1'b1;
      in4  = {4{32'h4100_0000}};
      @(posedge clk); #1;
      chk("t4_hold_stb", 32'(ostb4), 32'd1);
      chk("t4_hold_result", res4, 32'h4140_0000);
      chk("t4_hold_busy", 32'(busy4), 32'd1);
    end
    stb4   = 1'b0;
    obusy4 = 1'b0;
    release4("t4");
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_no_spurious_stb", 32'(ostb4), 32'd0);
    end

    // 5: reset while waiting on the multiplier, then a clean bundle
    send4(t1);
    n = 0;
    while (dbg4.state != WAIT_RES && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reached_wait_res", 32'(dbg4.state), 32'(WAIT_RES));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_busy_after_rst", 32'(busy4), 32'd0);
    chk("t5_stb_after_rst", 32'(ostb4), 32'd0);
    chk("t5_state_after_rst", 32'(dbg4.state), 32'(IDLE));
    s0 = starts4;
    send4({4{32'h3F80_0000}});
    wait4(r, lat);
    chk("t5_result", r, 32'h3F80_0000);
    chk("t5_mult_starts", starts4 - s0, 32'd3);
    release4("t5");

    // 6a: N_OPS=2, 3*4 = 12.0
    stb2 = 1'b1;
    in2  = {32'h4080_0000, 32'h4040_0000};
    @(posedge clk); #1;
    stb2 = 1'b0;
    n = 0;
    while (!ostb2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_n2_stb", 32'(ostb2), 32'd1);
    chk("t6_n2_result", res2, 32'h4140_0000);

    // 6b: N_OPS=16, sixteen 2.0 operands = 2^16
    stb16 = 1'b1;
    in16  = {16{32'h4000_0000}};
    @(posedge clk); #1;
    stb16 = 1'b0;
    n = 0;
    while (!ostb16 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_n16_stb", 32'(ostb16), 32'd1);
    chk("t6_n16_result", res16, 32'h4780_0000);
    @(posedge clk); #1;

    // Random bundles against the real-arithmetic model, random backpressure
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 4; i++) ops[32*i +: 32] = rand_op();
      exp_q.push_back(ref_prod4(ops));
      s0     = starts4;
      obusy4 = 1'($urandom_range(0, 1));
      send4(ops);
      wait4(r, lat);
      chk("rand_result", r, exp_q[0]);
      chk("rand_mult_starts", starts4 - s0, 32'(exp_starts4(ops)));
      hold = obusy4 ? $urandom_range(1, 4) : 0;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      chk("rand_result_held", res4, exp_q.pop_front());
      obusy4 = 1'b0;
      release4("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
